rf_opfetch: RTL and testbench

Operand-fetch stage between instruction decode and execute. Drives the register file's two asynchronous read ports and registers both operands into a one-entry output stage. A per-register scoreboard stalls RAW and WAW hazards. Operands being written back in the same cycle are forwarded, since a same-cycle register file read returns the old value.

---
 rtl/rf_opfetch.sv | 119 +++++++++++
 tb/tb_rf_opfetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_opfetch.sv
// Operand-fetch stage: scoreboarded RAW/WAW stalls, same-cycle writeback forwarding, one-entry output register.
// Optional build macro RF_ZERO_REG_EN makes register 0 a constant zero.
module rf_opfetch #(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_id_valid,
    output logic               o_id_ready,
    input  logic [BW_ADDR-1:0] i_id_rs0_addr,
    input  logic [BW_ADDR-1:0] i_id_rs1_addr,
    input  logic [BW_ADDR-1:0] i_id_rd_addr,
    input  logic               i_id_rd_en,
    output logic [BW_ADDR-1:0] o_rf_rd_addr0,
    output logic [BW_ADDR-1:0] o_rf_rd_addr1,
    input  logic [BW_DATA-1:0] i_rf_rd_data0,
    input  logic [BW_DATA-1:0] i_rf_rd_data1,
    input  logic               i_wb_en,
    input  logic [BW_ADDR-1:0] i_wb_addr,
    input  logic [BW_DATA-1:0] i_wb_data,
    output logic               o_ex_valid,
    input  logic               i_ex_ready,
    output logic [BW_DATA-1:0] o_ex_rs0_data,
    output logic [BW_DATA-1:0] o_ex_rs1_data,
    output logic [BW_ADDR-1:0] o_ex_rd_addr,
    output logic               o_ex_rd_en
);
    localparam int NREG = 2 ** BW_ADDR;

    logic [NREG-1:0]    r_busy;
    logic [NREG-1:0]    w_busy_next;
    logic               r_ex_valid;
    logic [BW_DATA-1:0] r_ex_rs0_data;
    logic [BW_DATA-1:0] r_ex_rs1_data;
    logic [BW_ADDR-1:0] r_ex_rd_addr;
    logic               r_ex_rd_en;

    logic               w_clr_rs0;
    logic               w_clr_rs1;
    logic               w_clr_rd;
    logic               w_src0_zero;
    logic               w_src1_zero;
    logic               w_rd_en_eff;
    logic               w_hazard;
    logic               w_accept;
    logic [BW_DATA-1:0] w_op0;
    logic [BW_DATA-1:0] w_op1;

    assign o_rf_rd_addr0 = i_id_rs0_addr;
    assign o_rf_rd_addr1 = i_id_rs1_addr;

`ifdef RF_ZERO_REG_EN
    assign w_src0_zero = (i_id_rs0_addr == '0);
    assign w_src1_zero = (i_id_rs1_addr == '0);
    assign w_rd_en_eff = i_id_rd_en && (i_id_rd_addr != '0);
`else
    assign w_src0_zero = 1'b0;
    assign w_src1_zero = 1'b0;
    assign w_rd_en_eff = i_id_rd_en;
`endif

    // A register being written back this cycle is no longer a hazard; its value comes from the writeback bus.
    assign w_clr_rs0 = i_wb_en && (i_wb_addr == i_id_rs0_addr);
    assign w_clr_rs1 = i_wb_en && (i_wb_addr == i_id_rs1_addr);
    assign w_clr_rd  = i_wb_en && (i_wb_addr == i_id_rd_addr);

    assign w_hazard = (r_busy[i_id_rs0_addr] && !w_clr_rs0)
                   || (r_busy[i_id_rs1_addr] && !w_clr_rs1)
                   || (w_rd_en_eff && r_busy[i_id_rd_addr] && !w_clr_rd);

    assign o_id_ready = !w_hazard && (!r_ex_valid || i_ex_ready);
    assign w_accept   = i_id_valid && o_id_ready;

    assign w_op0 = w_src0_zero ? '0 : (w_clr_rs0 ? i_wb_data : i_rf_rd_data0);
    assign w_op1 = w_src1_zero ? '0 : (w_clr_rs1 ? i_wb_data : i_rf_rd_data1);

    // Per-register scoreboard: a new writer's set overrides a same-cycle writeback clear.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            assign w_busy_next[gi] =
                (w_accept && w_rd_en_eff && (i_id_rd_addr == BW_ADDR'(gi))) ? 1'b1 :
                (i_wb_en && (i_wb_addr == BW_ADDR'(gi)))                    ? 1'b0 :
                r_busy[gi];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_rs0_data <= '0;
            r_ex_rs1_data <= '0;
            r_ex_rd_addr  <= '0;
            r_ex_rd_en    <= 1'b0;
        end else if (w_accept) begin
            r_ex_valid    <= 1'b1;
            r_ex_rs0_data <= w_op0;
            r_ex_rs1_data <= w_op1;
            r_ex_rd_addr  <= i_id_rd_addr;
            r_ex_rd_en    <= w_rd_en_eff;
        end else if (i_ex_ready) begin
            r_ex_valid    <= 1'b0;
        end
    end

    assign o_ex_valid    = r_ex_valid;
    assign o_ex_rs0_data = r_ex_rs0_data;
    assign o_ex_rs1_data = r_ex_rs1_data;
    assign o_ex_rd_addr  = r_ex_rd_addr;
    assign o_ex_rd_en    = r_ex_rd_en;
endmodule

// File: tb/tb_rf_opfetch.sv
// Scoreboard bench for rf_opfetch: directed hazard/forward/reset scenarios, then randomized traffic
// against a behavioural model of the register file and per-register pending-writer table.
module tb_rf_opfetch;
    localparam int BD = 32;
    localparam int BA = 5;
`ifdef RF_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    typedef struct {
        logic [BD-1:0] d0;
        logic [BD-1:0] d1;
        logic [BA-1:0] rd;
        logic          rden;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid = 1'b0;
    logic          id_ready;
    logic [BA-1:0] rs0 = '0, rs1 = '0, rd = '0;
    logic          rd_en = 1'b0;
    logic [BA-1:0] rf_a0, rf_a1;
    logic [BD-1:0] rf_d0, rf_d1;
    logic          wb_en = 1'b0;
    logic [BA-1:0] wb_addr = '0;
    logic [BD-1:0] wb_data = '0;
    logic          ex_valid;
    logic          ex_ready = 1'b1;
    logic [BD-1:0] ex_d0, ex_d1;
    logic [BA-1:0] ex_rd;
    logic          ex_rden;

    logic [BD-1:0] rf [32];
    bit            busy [32];
    exp_t          sb [$];
    int            acc_now = 0;
    int            n_checks = 0;
    int            n_pass = 0;
    bit            held_v = 1'b0;
    logic [69:0]   held;

    assign rf_d0 = rf[rf_a0];
    assign rf_d1 = rf[rf_a1];

    always #5 clk = ~clk;

    rf_opfetch #(.BW_DATA(BD), .BW_ADDR(BA)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_valid(id_valid), .o_id_ready(id_ready),
        .i_id_rs0_addr(rs0), .i_id_rs1_addr(rs1),
        .i_id_rd_addr(rd), .i_id_rd_en(rd_en),
        .o_rf_rd_addr0(rf_a0), .o_rf_rd_addr1(rf_a1),
        .i_rf_rd_data0(rf_d0), .i_rf_rd_data1(rf_d1),
        .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .o_ex_valid(ex_valid), .i_ex_ready(ex_ready),
        .o_ex_rs0_data(ex_d0), .o_ex_rs1_data(ex_d1),
        .o_ex_rd_addr(ex_rd), .o_ex_rd_en(ex_rden)
    );

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [BD-1:0] ref_operand(input logic [BA-1:0] rs, input bit we,
                                                  input logic [BA-1:0] wa, input logic [BD-1:0] wd);
        if (ZR && rs == 0) return '0;
        if (we && wa == rs) return wd;
        return rf[rs];
    endfunction

    // One cycle of stimulus; the model decides acceptance and predicts the registered result.
    task automatic drive(input bit v, input logic [BA-1:0] a0, input logic [BA-1:0] a1,
                         input logic [BA-1:0] d, input bit den, input bit we,
                         input logic [BA-1:0] wa, input logic [BD-1:0] wd, input bit er);
        bit   den_eff, haz, exp_rdy, acc;
        exp_t e;
        acc_now  = 0;
        id_valid = v; rs0 = a0; rs1 = a1; rd = d; rd_en = den;
        wb_en = we; wb_addr = wa; wb_data = wd; ex_ready = er;
        #1;
        den_eff = den && !(ZR && d == 0);
        haz = (busy[a0] && !(we && wa == a0)) || (busy[a1] && !(we && wa == a1))
           || (den_eff && busy[d] && !(we && wa == d));
        exp_rdy = !haz && (sb.size() == 0 || er);
        chk("id_ready", 80'(id_ready), 80'(exp_rdy));
        chk("rf_addr", 80'({rf_a0, rf_a1}), 80'({a0, a1}));
        acc = v && exp_rdy;
        if (acc) begin
            e.d0 = ref_operand(a0, we, wa, wd);
            e.d1 = ref_operand(a1, we, wa, wd);
            e.rd = d;
            e.rden = den_eff;
            sb.push_back(e);
            acc_now = 1;
        end
        @(posedge clk);
        #1;
        if (we) begin
            busy[wa] = 1'b0;
            rf[wa] = wd;
        end
        if (acc && den_eff) busy[d] = 1'b1;
    endtask

    task automatic do_reset();
        acc_now = 0;
        rst = 1'b1; id_valid = 1'b0; wb_en = 1'b0; ex_ready = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        for (int i = 0; i < 32; i++) busy[i] = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_valid", 80'(ex_valid), 80'(0));
        chk("rst_data", 80'({ex_d0, ex_d1}), 80'(0));
        chk("rst_rd", 80'({ex_rd, ex_rden}), 80'(0));
    endtask

    // Monitor: pops the scoreboard on each output handshake and checks hold stability under backpressure.
    always @(negedge clk) begin
        exp_t        e;
        logic [69:0] cur;
        bit          exp_v;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            cur   = {ex_d0, ex_d1, ex_rd, ex_rden};
            exp_v = (sb.size() > acc_now);
            chk("ex_valid", 80'(ex_valid), 80'(exp_v));
            if (held_v) chk("ex_hold", 80'(cur), 80'(held));
            if (ex_valid && ex_ready && exp_v) begin
                e = sb.pop_front();
                chk("ex_out", 80'(cur), 80'({e.d0, e.d1, e.rd, e.rden}));
            end
            held_v = ex_valid && !ex_ready;
            held   = cur;
        end
    end

    initial begin
        int          nb;
        logic [BA-1:0] blist [32];
        bit          we;
        logic [BA-1:0] wa;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'hFFFF;
        rf[3] = 32'h11;
        rf[4] = 32'h22;
        do_reset();

        // independent issue
        drive(1, 3, 4, 0, 0, 0, 0, 0, 1);
        drive(1, 4, 3, 1, 0, 0, 0, 0, 1);
        // RAW stall then same-cycle forward
        drive(1, 1, 2, 5, 1, 0, 0, 0, 1);
        drive(1, 5, 1, 0, 0, 0, 0, 0, 1);
        drive(1, 5, 1, 0, 0, 0, 0, 0, 1);
        drive(1, 5, 1, 0, 0, 1, 5, 32'hABCD, 1);
        // backpressure for 3 cycles
        drive(1, 6, 7, 8, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(1, 2, 3, 0, 0, 0, 0, 0, 0);
        drive(1, 2, 3, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 8, 32'h88, 1);
        // WAW: stall until r7 writeback, then r7 busy again
        drive(1, 1, 2, 7, 1, 0, 0, 0, 1);
        drive(1, 3, 4, 7, 1, 0, 0, 0, 1);
        drive(1, 3, 4, 7, 1, 0, 0, 0, 1);
        drive(1, 3, 4, 7, 1, 1, 7, 32'h77, 1);
        drive(1, 7, 1, 0, 0, 0, 0, 0, 1);
        drive(1, 7, 1, 0, 0, 1, 7, 32'h777, 1);
        // register 0 as source and as back-to-back destination
        drive(1, 0, 3, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(1, 3, 4, 0, 1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 0, 32'hFFFF, 1);
        // reset with r9 busy and output held
        drive(1, 1, 2, 9, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        drive(1, 9, 1, 0, 0, 0, 0, 0, 1);

        for (int n = 0; n < 3000; n++) begin
            nb = 0;
            for (int i = 0; i < 32; i++) if (busy[i]) begin blist[nb] = BA'(i); nb++; end
            we = 1'b0;
            wa = BA'($urandom_range(0, 31));
            if (nb > 0 && $urandom_range(0, 99) < 50) begin
                we = 1'b1;
                wa = blist[$urandom_range(0, nb - 1)];
            end else if ($urandom_range(0, 99) < 10) begin
                we = 1'b1;
            end
            drive($urandom_range(0, 99) < 80, BA'($urandom_range(0, 31)), BA'($urandom_range(0, 31)),
                  BA'($urandom_range(0, 31)), $urandom_range(0, 1) == 1, we, wa, $urandom,
                  $urandom_range(0, 99) < 75);
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("sb_empty", 80'(sb.size()), 80'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
